// File: rtl/audio_tone_synth.sv
// audio_tone_synth: sample-rate tone generator for the I2S serializer.
// Phase-accumulator oscillator gated by an attack/sustain/release envelope.
// One registered stereo sample per in_clk edge (left == right).
// Optional feature: define SYNTH_TRIANGLE_EN to add the wave_sel input and a
// triangle waveform (t * env >>> 15); without it the block is square-only.
module audio_tone_synth #(
    parameter int ACC_W        = 24,
    parameter int AMP_MAX      = 16383,
    parameter int ATTACK_STEP  = 64,
    parameter int RELEASE_STEP = 32
) (
    input  logic             reset,
    input  logic             in_clk,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [ACC_W-1:0] note_inc,
    input  logic             note_on,
    input  logic [2:0]       volume,
`ifdef SYNTH_TRIANGLE_EN
    input  logic             wave_sel,
`endif
    output logic [15:0]      audio_left,
    output logic [15:0]      audio_right,
    output logic             busy
);

    localparam logic [15:0] AMP_MAX_V = 16'(AMP_MAX);
    localparam logic [15:0] ATK_V     = 16'(ATTACK_STEP);
    localparam logic [15:0] REL_V     = 16'(RELEASE_STEP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   phase_q, phase_d;
    logic [ACC_W-1:0]   inc_q, inc_d;
    logic [15:0]        env_q, env_d;
    logic [15:0]        audio_q, audio_d;

    logic               xfer;
    logic [ACC_W-1:0]   phase_step;
    logic [15:0]        env_up;
    logic signed [15:0] env_s;
    logic signed [15:0] wave;

    // State, oscillator, envelope and output registers
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            inc_q   <= '0;
            env_q   <= '0;
            audio_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            inc_q   <= inc_d;
            env_q   <= env_d;
            audio_q <= audio_d;
        end
    end

    assign note_ready = (state_q != ST_ATTACK);
    assign busy       = (state_q != ST_IDLE);
    assign xfer       = note_valid & note_ready;
    assign phase_step = phase_q + inc_q;
    // env never exceeds AMP_MAX <= 32767, so the 16-bit sum cannot wrap
    assign env_up     = env_q + ATK_V;

    // Next-state: a note transfer overrides any gate-driven transition
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        inc_d   = inc_q;
        env_d   = env_q;
        if (xfer) begin
            inc_d   = note_inc;
            state_d = ST_ATTACK;
            // retrigger from a sounding note keeps phase running so there is no click
            phase_d = (state_q == ST_IDLE) ? '0 : phase_step;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    phase_d = '0;
                    env_d   = '0;
                end
                ST_ATTACK: begin
                    phase_d = phase_step;
                    if (!note_on) begin
                        state_d = ST_RELEASE;
                    end else if (env_up >= AMP_MAX_V) begin
                        env_d   = AMP_MAX_V;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = env_up;
                    end
                end
                ST_SUSTAIN: begin
                    phase_d = phase_step;
                    if (!note_on) state_d = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (env_q <= REL_V) begin
                        env_d   = '0;
                        phase_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d   = env_q - REL_V;
                        phase_d = phase_step;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign env_s = $signed(env_q);

`ifdef SYNTH_TRIANGLE_EN
    logic [15:0]        p16;
    logic [14:0]        fold;
    logic signed [15:0] tri_t;
    logic signed [31:0] prod;
    logic               tri_unused;

    assign p16  = phase_q[ACC_W-1 -: 16];
    // rising half uses the low bits directly, falling half their complement
    assign fold = p16[15] ? ~p16[14:0] : p16[14:0];
    // {fold,0} spans 0..65534; flipping the MSB recentres it on zero
    assign tri_t = $signed({~fold[14], fold[13:0], 1'b0});
    assign prod  = tri_t * env_s;
    assign tri_unused = ^{prod[31], prod[14:0]};

    // Waveform select: square or triangle scaled by envelope
    always_comb begin
        wave = phase_q[ACC_W-1] ? -env_s : env_s;
        if (wave_sel) wave = prod[30:15];
    end
`else
    // Square wave: sign follows the phase MSB
    always_comb begin
        wave = phase_q[ACC_W-1] ? -env_s : env_s;
    end
`endif

    // Volume is an arithmetic attenuation of the pre-register sample
    always_comb begin
        audio_d = 16'(wave >>> volume);
    end

    assign audio_left  = audio_q;
    assign audio_right = audio_q;

endmodule

// File: tb/tb_audio_tone_synth.sv
// Scoreboard bench for audio_tone_synth: a cycle model predicts each sample,
// busy and note_ready when inputs are driven; results are compared after the edge.
module tb_audio_tone_synth;
    logic        reset, in_clk, note_valid, note_on, note_ready, busy;
    logic [23:0] note_inc;
    logic [2:0]  volume;
    logic [15:0] audio_left, audio_right;
    logic        wave_sel;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] aud;
        logic        bsy;
        logic        rdy;
    } exp_t;
    exp_t sb[$];

    // model state: 0 idle, 1 attack, 2 sustain, 3 release
    int          m_state;
    logic [23:0] m_phase, m_inc;
    int          m_env;

    audio_tone_synth dut (
        .reset(reset), .in_clk(in_clk), .note_valid(note_valid),
        .note_ready(note_ready), .note_inc(note_inc), .note_on(note_on),
        .volume(volume),
`ifdef SYNTH_TRIANGLE_EN
        .wave_sel(wave_sel),
`endif
        .audio_left(audio_left), .audio_right(audio_right), .busy(busy));

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_sample(input logic [23:0] ph, input int env,
                                             input logic [2:0] vol, input logic ws);
        int w;
        int p;
        int t;
        logic signed [15:0] w16;
        w = ph[23] ? -env : env;
        if (ws) begin
            p = int'(ph[23:8]);
            t = (p < 32768) ? (2 * p - 32768) : (98302 - 2 * p);
            w = (t * env) >>> 15;
        end
        w16 = w[15:0];
        return 16'(w16 >>> vol);
    endfunction

    function automatic bit model_ready();
        return m_state != 1;
    endfunction

    // Advance model one edge, push expectation, clock DUT, compare
    task automatic step(input string tag);
        exp_t e, o;
        bit   ws;
        logic [23:0] stepd;
`ifdef SYNTH_TRIANGLE_EN
        ws = wave_sel;
`else
        ws = 1'b0;
`endif
        e.aud = m_sample(m_phase, m_env, volume, ws);
        stepd = m_phase + m_inc;
        if (note_valid && model_ready()) begin
            m_phase = (m_state == 0) ? 24'd0 : stepd;
            m_inc   = note_inc;
            m_state = 1;
        end else begin
            case (m_state)
                1: begin
                    m_phase = stepd;
                    if (!note_on) m_state = 3;
                    else begin
                        m_env = (m_env + 64 > 16383) ? 16383 : m_env + 64;
                        if (m_env == 16383) m_state = 2;
                    end
                end
                2: begin
                    m_phase = stepd;
                    if (!note_on) m_state = 3;
                end
                3: begin
                    m_env = (m_env - 32 < 0) ? 0 : m_env - 32;
                    if (m_env == 0) begin m_state = 0; m_phase = 0; end
                    else m_phase = stepd;
                end
                default: ;
            endcase
        end
        e.bsy = (m_state != 0);
        e.rdy = (m_state != 1);
        sb.push_back(e);
        @(posedge in_clk);
        #1;
        o = sb.pop_front();
        chk({tag, "_left"}, 32'(audio_left), 32'(o.aud));
        chk({tag, "_right"}, 32'(audio_right), 32'(o.aud));
        chk({tag, "_busy"}, 32'(busy), 32'(o.bsy));
        chk({tag, "_ready"}, 32'(note_ready), 32'(o.rdy));
    endtask

    task automatic model_reset();
        m_state = 0; m_phase = '0; m_inc = '0; m_env = 0;
    endtask

    initial begin
        int n;
        reset = 1'b1; note_valid = 1'b1; note_on = 1'b0; note_inc = 24'h400000;
        volume = 3'd0; wave_sel = 1'b0;
        model_reset();

        // reset holds everything cleared even with a note offered
        for (int i = 0; i < 3; i++) begin
            @(posedge in_clk); #1;
            chk("rst_audio", 32'(audio_left), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'(note_ready), 32'd1);
        end
        note_valid = 1'b0;
        reset = 1'b0;
        step("idle");
        step("idle");

        // note from idle, attack then sustain square
        note_valid = 1'b1; note_inc = 24'h400000; note_on = 1'b1;
        step("note1");
        note_valid = 1'b0;
        for (int i = 0; i < 300; i++) step("attack_sustain");
        chk("sustain_state", 32'(m_state), 32'd2);

        // release to idle
        note_on = 1'b0;
        for (int i = 0; i < 520; i++) step("release");
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_audio", 32'(audio_left), 32'd0);

        // new note; second note offered mid-attack stalls until sustain
        note_valid = 1'b1; note_inc = 24'h400000; note_on = 1'b1;
        step("note2");
        for (int i = 0; i < 10; i++) begin note_valid = 1'b0; step("attack2"); end
        note_valid = 1'b1; note_inc = 24'h200000;
        n = 0;
        while (m_inc != 24'h200000 && n < 400) begin step("stall"); n++; end
        chk("stall_accepted", 32'(m_inc == 24'h200000), 32'd1);
        note_valid = 1'b0;
        for (int i = 0; i < 20; i++) step("new_inc");

        // volume shift in sustain
        volume = 3'd2;
        for (int i = 0; i < 16; i++) step("vol2");
        volume = 3'd0;

`ifdef SYNTH_TRIANGLE_EN
        wave_sel = 1'b1;
        note_valid = 1'b1; note_inc = 24'h040000;
        step("tri_note");
        note_valid = 1'b0;
        for (int i = 0; i < 130; i++) step("triangle");
        wave_sel = 1'b0;
`endif

        // reset in the middle of release clears outputs without an edge
        note_on = 1'b0;
        for (int i = 0; i < 100; i++) step("release2");
        chk("mid_release_env", 32'(m_env > 0), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_audio", 32'(audio_left), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(note_ready), 32'd1);
        model_reset();
        @(posedge in_clk); #1;
        reset = 1'b0;
        note_valid = 1'b1; note_inc = 24'h400000; note_on = 1'b1;
        step("restart");
        note_valid = 1'b0;
        for (int i = 0; i < 20; i++) step("restart_run");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
